// File: rtl/pwm_compare_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : pwm_compare_scheduler
// Brief    : Multi-channel PWM that time-shares one external 32-bit less-than
//            comparator across NCH duty compares and one period compare.
// Revision : 1.0
//============================================================================
module pwm_compare_scheduler #(
    parameter int NCH = 4,
    parameter int AW  = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic           cfg_we,
    input  logic [AW-1:0]  cfg_addr,
    input  logic [31:0]    cfg_data,
    output logic [31:0]    cmp_a,
    output logic [31:0]    cmp_b,
    input  logic           cmp_lt,
    output logic [NCH-1:0] pwm_out,
    output logic           period_start,
    output logic [AW-1:0]  slot
);

    localparam logic [AW-1:0] LAST_SLOT = AW'(NCH);

    logic [AW-1:0]  slot_q, slot_d;
    logic [31:0]    count_q, count_d;
    logic [31:0]    top_sh_q, top_sh_d;
    logic [31:0]    top_act_q, top_act_d;
    logic [31:0]    duty_sh_q  [NCH];
    logic [31:0]    duty_sh_d  [NCH];
    logic [31:0]    duty_act_q [NCH];
    logic [31:0]    duty_act_d [NCH];
    logic [NCH-1:0] pwm_q, pwm_d;
    logic           period_start_q, period_start_d;
    logic [31:0]    cmp_b_sel;

    // Slot NCH (and any unused slot code) presents the period terminal.
    always_comb begin
        cmp_b_sel = top_act_q;
        for (int k = 0; k < NCH; k++) begin
            if (slot_q == AW'(k)) begin
                cmp_b_sel = duty_act_q[k];
            end
        end
    end

    always_comb begin
        top_sh_d = top_sh_q;
        for (int k = 0; k < NCH; k++) begin
            duty_sh_d[k] = duty_sh_q[k];
        end
        if (cfg_we) begin
            if (cfg_addr == LAST_SLOT) begin
                top_sh_d = cfg_data;
            end
            for (int k = 0; k < NCH; k++) begin
                if (cfg_addr == AW'(k)) begin
                    duty_sh_d[k] = cfg_data;
                end
            end
        end
    end

    // Shadows are read from the register, so a write landing on the wrap
    // cycle only takes effect at the following wrap.
    always_comb begin
        slot_d         = slot_q;
        count_d        = count_q;
        pwm_d          = pwm_q;
        period_start_d = 1'b0;
        top_act_d      = top_act_q;
        for (int k = 0; k < NCH; k++) begin
            duty_act_d[k] = duty_act_q[k];
        end

        if (!en) begin
            slot_d    = '0;
            count_d   = '0;
            pwm_d     = '0;
            top_act_d = top_sh_q;
            for (int k = 0; k < NCH; k++) begin
                duty_act_d[k] = duty_sh_q[k];
            end
        end else if (slot_q == LAST_SLOT) begin
            slot_d = '0;
            if (cmp_lt) begin
                count_d = count_q + 32'd1;
            end else begin
                count_d        = '0;
                period_start_d = 1'b1;
                top_act_d      = top_sh_q;
                for (int k = 0; k < NCH; k++) begin
                    duty_act_d[k] = duty_sh_q[k];
                end
            end
        end else begin
            slot_d = slot_q + AW'(1);
            for (int k = 0; k < NCH; k++) begin
                if (slot_q == AW'(k)) begin
                    pwm_d[k] = cmp_lt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q         <= '0;
            count_q        <= '0;
            top_sh_q       <= '0;
            top_act_q      <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                duty_sh_q[k]  <= '0;
                duty_act_q[k] <= '0;
            end
        end else begin
            slot_q         <= slot_d;
            count_q        <= count_d;
            top_sh_q       <= top_sh_d;
            top_act_q      <= top_act_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            for (int k = 0; k < NCH; k++) begin
                duty_sh_q[k]  <= duty_sh_d[k];
                duty_act_q[k] <= duty_act_d[k];
            end
        end
    end

    assign cmp_a        = count_q;
    assign cmp_b        = cmp_b_sel;
    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign slot         = slot_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_compare_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : tb_pwm_compare_scheduler
// Brief    : Bench for pwm_compare_scheduler; per-period high-time scoreboard.
// Revision : 1.0
//============================================================================
module tb_pwm_compare_scheduler;

    localparam int NCH = 4;
    localparam int AW  = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           en;
    logic           cfg_we;
    logic [AW-1:0]  cfg_addr;
    logic [31:0]    cfg_data;
    logic [31:0]    cmp_a;
    logic [31:0]    cmp_b;
    logic           cmp_lt;
    logic [NCH-1:0] pwm_out;
    logic           period_start;
    logic [AW-1:0]  slot;

    int checks = 0;
    int errors = 0;

    int exp_len_q [$];
    int exp_hi_q  [$];

    bit mon_on   = 1'b0;
    bit win_open = 1'b0;
    int win_len  = 0;
    int hi_cnt [NCH];

    always #5 clk = ~clk;

    // External comparator model.
    assign cmp_lt = (cmp_a < cmp_b);

    pwm_compare_scheduler #(
        .NCH(NCH),
        .AW (AW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .cmp_lt      (cmp_lt),
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .slot        (slot)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic push_win(input int len, input int h0, input int h1, input int h2, input int h3);
        exp_len_q.push_back(len);
        exp_hi_q.push_back(h0);
        exp_hi_q.push_back(h1);
        exp_hi_q.push_back(h2);
        exp_hi_q.push_back(h3);
    endtask

    // Returns one cycle after the next period_start pulse.
    task automatic wait_ps();
        int n;
        n = 0;
        while (period_start !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("wait_period_start", 64'(period_start), 64'd1);
        tick();
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (exp_len_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check("scoreboard_drain", 64'(exp_len_q.size()), 64'd0);
        exp_len_q.delete();
        exp_hi_q.delete();
    endtask

    // A window runs from one period_start pulse up to the cycle before the next.
    always @(negedge clk) begin
        if (!mon_on || !reset_n || !en) begin
            win_open = 1'b0;
        end else begin
            if (period_start) begin
                if (win_open && exp_len_q.size() > 0) begin
                    check("period_len", 64'(win_len), 64'(exp_len_q.pop_front()));
                    for (int k = 0; k < NCH; k++) begin
                        check($sformatf("high_time_ch%0d", k), 64'(hi_cnt[k]), 64'(exp_hi_q.pop_front()));
                    end
                end
                win_open = 1'b1;
                win_len  = 0;
                for (int k = 0; k < NCH; k++) hi_cnt[k] = 0;
            end
            if (win_open) begin
                win_len++;
                for (int k = 0; k < NCH; k++) hi_cnt[k] += int'(pwm_out[k]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        en       = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_slot", 64'(slot), 64'd0);
        check("rst_pwm", 64'(pwm_out), 64'd0);
        check("rst_period_start", 64'(period_start), 64'd0);
        check("rst_count", 64'(cmp_a), 64'd0);
        repeat (3) tick();
        check("idle_pwm", 64'(pwm_out), 64'd0);
        check("idle_slot", 64'(slot), 64'd0);

        // Basic PWM, TOP=9.
        mon_on = 1'b1;
        cfg_write(4'd4, 32'd9);
        cfg_write(4'd0, 32'd5);
        cfg_write(4'd1, 32'd0);
        cfg_write(4'd2, 32'd10);
        cfg_write(4'd3, 32'd3);
        tick();
        en = 1'b1;
        check("start_slot", 64'(slot), 64'd0);
        check("start_count", 64'(cmp_a), 64'd0);
        check("start_duty0", 64'(cmp_b), 64'd5);
        repeat (3) push_win(50, 25, 0, 50, 15);
        tick();
        check("slot_advance", 64'(slot), 64'd1);
        drain(400);

        // Mid-period duty change applies only from the next wrap.
        wait_ps();
        push_win(50, 25, 0, 50, 15);
        repeat (2) push_win(50, 10, 0, 50, 15);
        repeat (20) tick();
        cfg_write(4'd0, 32'd2);
        drain(400);

        // TOP write in the exact wrap cycle.
        wait_ps();
        repeat (2) push_win(50, 10, 0, 50, 15);
        repeat (2) push_win(25, 10, 0, 25, 15);
        repeat (48) tick();
        check("wrap_cycle_slot", 64'(slot), 64'(NCH));
        cfg_write(4'd4, 32'd4);
        drain(400);

        // TOP=0: wrap every scan.
        cfg_write(4'd4, 32'd0);
        cfg_write(4'd0, 32'd1);
        wait_ps();
        wait_ps();
        repeat (4) push_win(5, 5, 0, 5, 5);
        drain(100);

        // TOP at full scale: counter keeps climbing, no wrap.
        cfg_write(4'd4, 32'hFFFF_FFFF);
        wait_ps();
        repeat (3) tick();
        check("max_top_slot", 64'(slot), 64'(NCH));
        check("max_top_cmp_b", 64'(cmp_b), 64'hFFFF_FFFF);
        check("max_top_count0", 64'(cmp_a), 64'd0);
        repeat (5) tick();
        check("max_top_count1", 64'(cmp_a), 64'd1);
        repeat (5) tick();
        check("max_top_count2", 64'(cmp_a), 64'd2);
        check("max_top_pwm", 64'(pwm_out), 64'b1100);

        // Pending shadows load while en is low.
        cfg_write(4'd4, 32'd9);
        cfg_write(4'd0, 32'd7);
        en = 1'b0;
        tick();
        check("en_low_pwm", 64'(pwm_out), 64'd0);
        check("en_low_slot", 64'(slot), 64'd0);
        check("en_low_count", 64'(cmp_a), 64'd0);
        check("en_low_period_start", 64'(period_start), 64'd0);
        repeat (2) tick();
        en = 1'b1;
        check("restart_slot", 64'(slot), 64'd0);
        check("restart_count", 64'(cmp_a), 64'd0);
        check("restart_duty0", 64'(cmp_b), 64'd7);
        repeat (2) push_win(50, 35, 0, 50, 15);
        drain(300);

        // Asynchronous reset mid-run.
        tick();
        check("pre_reset_pwm2", 64'(pwm_out[2]), 64'd1);
        mon_on = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_pwm", 64'(pwm_out), 64'd0);
        check("async_rst_slot", 64'(slot), 64'd0);
        check("async_rst_count", 64'(cmp_a), 64'd0);
        check("async_rst_period_start", 64'(period_start), 64'd0);
        en = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        check("post_rst_pwm", 64'(pwm_out), 64'd0);
        check("post_rst_slot", 64'(slot), 64'd0);
        check("post_rst_duty0", 64'(cmp_b), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_compare_scheduler.md
# pwm_compare_scheduler

Time-multiplexed multi-channel PWM controller for the motion-control overlay. It owns one 32-bit period counter and sequences a single shared 32-bit unsigned less-than comparator across NCH duty compares plus one period-terminal compare per scan. It produces NCH registered PWM outputs and double-buffered duty/period configuration. The comparator itself sits outside this block: the block drives its A/B operands and samples its X result.

## Interface
Parameters:
- NCH, 4: number of PWM channels (1..15).
- AW, 4: config address width; must satisfy 2^AW ≥ NCH+1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; sampled each cycle.
- cfg_we  in  1  config write strobe, one write per asserted cycle.
- cfg_addr  in  AW  0..NCH-1 selects duty shadow k; NCH selects TOP shadow; other values ignored.
- cfg_data  in  32  write data.
- cmp_a  out  32  comparator operand A (combinational from state).
- cmp_b  out  32  comparator operand B (combinational from state).
- cmp_lt  in  1  comparator result, 1 when cmp_a < cmp_b unsigned, combinational, same cycle.
- pwm_out  out  NCH  registered PWM outputs.
- period_start  out  1  one-cycle pulse on the cycle after the counter wraps to 0.
- slot  out  AW  current scan slot, for debug/verification.

## Operation
- State: slot counter 0..NCH; count[31:0]; duty_sh[k], top_sh (shadows); duty_act[k], top_act (active).
- Scan = NCH+1 cycles. Slot k<NCH: cmp_a=count, cmp_b=duty_act[k]; at clock edge pwm_out[k] <= cmp_lt.
- Slot NCH: cmp_a=count, cmp_b=top_act. If cmp_lt: count <= count+1. Else count <= 0, duty_act <= duty_sh, top_act <= top_sh, period_start pulses next cycle.
- Slot advances k -> k+1 each cycle, NCH -> 0.
- Semantics: pwm_out[k] high for count in [0, duty_act[k]); period = TOP+1 ticks = (TOP+1)(NCH+1) clocks.
- duty=0: always low. duty>TOP: always high. TOP=0: count stays 0, wrap every scan. No overflow: increment only when count < TOP.
- Config writes go to shadows only, any time. Write to an address in the same cycle as a wrap: active loads the old shadow value; the new value applies at the next wrap.
- en=0: slot <= 0, count <= 0, pwm_out <= 0, active <= shadows every cycle, period_start=0; cmp_a/cmp_b still driven per slot 0 and ignored. Config writes still accepted.
- en rising: first slot-0 compare occurs the same cycle en is sampled high, with count=0.

## Timing
- Reset (async assert, sync release): slot=0, count=0, pwm_out=0, period_start=0, all shadows and active registers = 0.
- Compare latency: pwm_out[k] updates 1 clock after slot k is presented. Channels are skewed by one clock each, which is acceptable for the drive stage.
- Duty/TOP write -> effect: from the next wrap (≥1 scan) after the write cycle.
- cmp_lt is assumed valid within one clk period; the path cmp_a/cmp_b -> cmp_lt is the critical path, with no pipelining.
- Reset asserted mid-scan: all state clears immediately. Outputs are low until en has been high for ≥1 slot.

## Test plan
- Reset: assert reset_n=0 mid-run with pwm_out nonzero -> pwm_out=0, slot=0, count=0 asynchronously. After release with en=0, everything is held at 0.
- Basic PWM: NCH=4, TOP=9, duty0=5, duty1=0, duty2=10, duty3=3, en=1 -> period_start every 50 clk. pwm_out[0] high 25 of 50 clk, [1] always 0, [2] always 1, [3] high 15 of 50.
- Shadow timing: mid-period write duty0=2 -> pwm_out[0] keeps the duty=5 pattern until period_start, then high 10 of 50 clk.
- Write-at-wrap collision: write TOP=4 in the exact slot-NCH cycle of a wrap -> the next period is still 50 clk; the following periods are 25 clk.
- TOP=0 with duty0=1 -> period_start every 5 clk, pwm_out[0] constantly 1. TOP=0xFFFFFFFF with count forced near the max via long-run/backdoor -> no overflow, and the wrap goes to 0.
- en toggle: en=0 for 3 clk mid-period -> pwm_out=0, and the restart has count=0, slot=0. Pending shadows are active on restart.
